mem_access_ctrl: RTL and testbench
==================================

// Module: mem_access_ctrl
// PURPOSE
//  Parametrised MEM-stage controller for the pipelined ARM core, sitting between EXE_Reg outputs and MEM_Reg.
//  Maps ALU byte addresses onto a word-addressed external memory with a fixed number of wait states.
//  Drops ready to freeze the whole pipeline while an access is in flight.
//  Optionally holds a one-entry read buffer so that repeated loads complete with no stall.
// PARAMETERS
//  DATA_W       32    data width of store value, load data and external bus
//  ADDR_W       16    external word-address width
//  BASE_ADDR    1024  byte address mapped to external word 0
//  WAIT_STATES  4     external access latency in cycles, >=1
// PORTS
//  clk        in   1        pipeline clock
//  rst        in   1        asynchronous reset, active-high
//  mem_r_en   in   1        load request from EXE_Reg
//  mem_w_en   in   1        store request from EXE_Reg
//  alu_res    in   DATA_W   byte address
//  st_val     in   DATA_W   store data
//  ready      out  1        0 = freeze all pipeline registers and PC
//  mem_out    out  DATA_W   load result, valid while ready=1 for a load
//  ext_addr   out  ADDR_W   external word address
//  ext_we     out  1        external write strobe
//  ext_oe     out  1        external read strobe
//  ext_wdata  out  DATA_W   external write data
//  ext_rdata  in   DATA_W   external read data
// BEHAVIOUR
//  - Clocking and reset: one clock, clk; rst is asynchronous, active-high.
//  - Reset values: state=IDLE, ready=1, mem_out=0, ext_addr=0, ext_we=0, ext_oe=0, ext_wdata=0; read buffer invalid.
//  - Address mapping: word = (alu_res - BASE_ADDR) >> 2, truncated to ADDR_W bits (wraps modulo 2^ADDR_W).
//  - FSM IDLE -> ACCESS -> DONE -> IDLE:
//    IDLE: no request -> ready=1. Request seen -> ready=0 combinationally in the same cycle.
//      Latch word, st_val and the write flag; load cnt=WAIT_STATES-1; go to ACCESS.
//    ACCESS: ext_addr/ext_wdata come from latches; ext_we=write flag; ext_oe=!write flag; ready=0.
//      cnt decrements each cycle. At cnt==0, a read registers ext_rdata into mem_out; go to DONE.
//    DONE: ready=1 for exactly one cycle; strobes deasserted. The request still present is the same instruction and is ignored; go to IDLE.
//  - Latency: ready is low for WAIT_STATES+1 cycles per access; the pipeline advances on the DONE cycle.
//  - mem_r_en and mem_w_en both high: treated as a store; the read is dropped.
//  - Back-to-back requests: the instruction following DONE is evaluated fresh in IDLE; no access is merged or lost.
//  - Request deasserted mid-ACCESS (cannot occur under freeze): the access still completes.
//  - rst mid-access: the FSM aborts immediately, all outputs return to reset values, and no write completes after reset.
//  - mem_out holds its last load value across stores and idle cycles.
// CONFIGURATION
//  MEM_RDBUF_EN defined: one-entry buffer {valid, word tag, data}.
//    Load in IDLE with valid && tag==word (hit): ready stays 1, mem_out = buffer data combinationally that cycle, no external access.
//    Miss load fills the buffer at completion.
//    Store to the tagged word updates the buffer data (write-through). Store to another word leaves the buffer unchanged.
//  MEM_RDBUF_EN undefined: no buffer; every load takes the full WAIT_STATES+1 stall.
// TESTING (WAIT_STATES=4, BASE_ADDR=1024)
//  1. Store 32'hDEADBEEF to 1028 -> ext_addr=1, ext_we=1 for 4 cycles; ready low 5 cycles, then high 1 cycle.
//  2. Load 1028 after test 1 -> ext_oe=1 for 4 cycles; mem_out=32'hDEADBEEF when ready returns to 1.
//  3. Load 1032 then store 1036 back-to-back -> two separate 5-cycle stalls; both ext accesses occur in order.
//  4. rst during the 2nd ACCESS cycle of a store -> ext_we=0 and ready=1 immediately; a following load of that word returns the old value.
//  5. mem_r_en=mem_w_en=1, alu_res=1024, st_val=5 -> write of 5 to word 0; mem_out unchanged.
//  6. MEM_RDBUF_EN: load 1028 twice -> second load has no stall and mem_out=32'hDEADBEEF. Then store 7 to 1028 and load 1028 -> 7, no stall on the load.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: maps ALU byte addresses onto a word-addressed
// external memory with a fixed wait-state count, and freezes the pipeline
// (ready=0) while an access is in flight.
//
// Optional feature macro: MEM_RDBUF_EN
//   defined   -> one-entry read buffer {valid, tag, data}. Loads that hit
//                the buffer complete in the request cycle without a stall.
//   undefined -> every access takes the full WAIT_STATES+1 stall.
module mem_access_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 16,
    parameter int BASE_ADDR   = 1024,
    parameter int WAIT_STATES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [DATA_W-1:0] alu_res,
    input  logic [DATA_W-1:0] st_val,
    output logic              ready,
    output logic [DATA_W-1:0] mem_out,
    output logic [ADDR_W-1:0] ext_addr,
    output logic              ext_we,
    output logic              ext_oe,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic [DATA_W-1:0] ext_rdata
);

    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_STATES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic [DATA_W-1:0] mem_q;

    logic [ADDR_W-1:0] word;
    logic              req;
    logic              hit;
    logic              start;
    logic              last_cycle;

    // Byte address -> external word address; wraps modulo 2^ADDR_W.
    assign word = ADDR_W'((alu_res - DATA_W'(BASE_ADDR)) >> 2);

    // A request is never accepted while reset is held, so ready reads 1
    // during reset even if EXE_Reg still presents an access.
    assign req = (mem_r_en | mem_w_en) & ~rst;

`ifdef MEM_RDBUF_EN
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_tag;
    logic [DATA_W-1:0] buf_data;

    // Pure load (a simultaneous store wins) to the buffered word.
    assign hit = req & mem_r_en & ~mem_w_en & buf_valid & (buf_tag == word);
`else
    assign hit = 1'b0;
`endif

    // An external access starts only from IDLE and only on a buffer miss.
    assign start      = (state == IDLE) & req & ~hit;
    assign last_cycle = (state == ACCESS) & (cnt == '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ACCESS;
            ACCESS:  if (cnt == '0) next_state = DONE;
            // The request still present in DONE belongs to the instruction
            // that just completed; it is ignored.
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode: freeze, strobes and load-result mux
    always_comb begin
        ready  = 1'b1;
        ext_we = 1'b0;
        ext_oe = 1'b0;
        case (state)
            IDLE:    ready = ~start;
            ACCESS: begin
                ready  = 1'b0;
                ext_we = wr_q;
                ext_oe = ~wr_q;
            end
            DONE:    ready = 1'b1;
            default: ready = 1'b1;
        endcase
`ifdef MEM_RDBUF_EN
        mem_out = hit ? buf_data : mem_q;
`else
        mem_out = mem_q;
`endif
    end

    assign ext_addr  = addr_q;
    assign ext_wdata = wdata_q;

    // Request latches and wait-state counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            addr_q  <= word;
            wdata_q <= st_val;
            wr_q    <= mem_w_en;
            cnt     <= CNT_LOAD;
        end else if (state == ACCESS && cnt != '0) begin
            cnt     <= cnt - CNT_W'(1);
        end
    end

    // Load result register; holds across stores and idle cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      mem_q <= '0;
        else if (last_cycle && !wr_q) mem_q <= ext_rdata;
`ifdef MEM_RDBUF_EN
        else if (hit)                 mem_q <= buf_data;
`endif
    end

`ifdef MEM_RDBUF_EN
    // Read buffer: filled by a completed miss load, written through by a
    // completed store to the tagged word. Updates happen only at access
    // completion so an aborted access leaves the buffer untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_valid <= 1'b0;
            buf_tag   <= '0;
            buf_data  <= '0;
        end else if (last_cycle) begin
            if (!wr_q) begin
                buf_valid <= 1'b1;
                buf_tag   <= addr_q;
                buf_data  <= ext_rdata;
            end else if (buf_valid && buf_tag == addr_q) begin
                buf_data  <= wdata_q;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, hand-written reset and
// read-buffer sequences, then randomized ops against a word-level model.
module tb_mem_access_ctrl;

    localparam int WS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_r_en, mem_w_en;
    logic [31:0] alu_res, st_val;
    logic        ready;
    logic [31:0] mem_out;
    logic [15:0] ext_addr;
    logic        ext_we, ext_oe;
    logic [31:0] ext_wdata, ext_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_ctrl #(.DATA_W(32), .ADDR_W(16), .BASE_ADDR(1024), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .alu_res(alu_res), .st_val(st_val), .ready(ready), .mem_out(mem_out),
        .ext_addr(ext_addr), .ext_we(ext_we), .ext_oe(ext_oe),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata)
    );

    always #5 clk = ~clk;

    // External SRAM: a write commits only if the strobe is held for the
    // full WS cycles; reads are combinational while ext_oe is high.
    logic [31:0] ext_mem [0:65535];
    int          we_run = 0;
    assign ext_rdata = ext_oe ? ext_mem[ext_addr] : 32'h0;

    always @(posedge clk) begin
        if (ext_we) begin
            if (we_run == WS - 1) begin
                ext_mem[ext_addr] <= ext_wdata;
                we_run <= 0;
            end else begin
                we_run <= we_run + 1;
            end
        end else begin
            we_run <= 0;
        end
    end

    // Reference model: word-addressed memory, last load value, and the word
    // of the most recent miss load (the only word a repeat load may hit).
    logic [31:0] ref_mem [int];
    logic [31:0] last_out;
    int          last_word;

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] d;
        d = (a - 32'd1024) >> 2;
        return int'(d & 32'hFFFF);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result of the last op
    int          op_low, op_we, op_oe;
    logic [15:0] op_addr;
    logic [31:0] op_out;
    bit          op_to;

    // Present one request (entered at posedge+1) and follow it until ready.
    task automatic do_op(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_r_en = r; mem_w_en = w; alu_res = a; st_val = d;
        op_low = 0; op_we = 0; op_oe = 0; op_to = 1'b1; op_addr = 16'h0; op_out = 32'h0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (ext_we) begin op_we++; op_addr = ext_addr; end
            if (ext_oe) begin op_oe++; op_addr = ext_addr; end
            if (ready) begin
                op_out = mem_out;
                op_to  = 1'b0;
                break;
            end
            op_low++;
        end
        @(posedge clk); #1;
        mem_r_en = 1'b0; mem_w_en = 1'b0;
    endtask

    // Model-predicted op with checks.
    task automatic run_op(input string tag, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d);
        int          wd;
        bit          is_st, is_ld, hit;
        logic [31:0] exp_out;
        wd    = word_of(a);
        is_st = w;
        is_ld = r && !w;
        hit   = 1'b0;
`ifdef MEM_RDBUF_EN
        hit = is_ld && (last_word == wd);
`endif
        if (is_ld) exp_out = ref_mem.exists(wd) ? ref_mem[wd] : 32'h0;
        else       exp_out = last_out;
        do_op(r, w, a, d);
        chk({tag, "_timeout"}, {31'h0, op_to}, 32'h0);
        if (!is_st && !is_ld || hit) begin
            chk({tag, "_stall"}, op_low, 0);
            chk({tag, "_noext"}, op_we + op_oe, 0);
        end else begin
            chk({tag, "_stall"}, op_low, WS + 1);
            chk({tag, "_strobe"}, is_st ? op_we : op_oe, WS);
            chk({tag, "_addr"}, {16'h0, op_addr}, wd & 32'hFFFF);
        end
        chk({tag, "_out"}, op_out, exp_out);
        if (is_st) ref_mem[wd] = d;
        if (is_ld) begin
            last_out  = exp_out;
            last_word = wd;
        end
    endtask

    typedef struct {
        logic        r, w;
        logic [31:0] a, d;
        int          low, we_n, oe_n;
        logic [15:0] addr;
        logic [31:0] out;
    } vec_t;

    vec_t tbl [9];

    initial begin
        for (int i = 0; i < 65536; i++) ext_mem[i] = 32'h0;
        last_out = 32'h0; last_word = -1;

        // r, w, addr, data, stall, we cycles, oe cycles, ext word, mem_out
        tbl[0] = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 5, 4, 0, 16'd1, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 32'd1028, 32'h0,        5, 0, 4, 16'd1, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 1'b0, 32'd1032, 32'h0,        5, 0, 4, 16'd2, 32'h0};
        tbl[3] = '{1'b0, 1'b1, 32'd1036, 32'hA5A5A5A5, 5, 4, 0, 16'd3, 32'h0};
        tbl[4] = '{1'b1, 1'b1, 32'd1024, 32'd5,        5, 4, 0, 16'd0, 32'h0};
        tbl[5] = '{1'b1, 1'b0, 32'd1036, 32'h0,        5, 0, 4, 16'd3, 32'hA5A5A5A5};
        tbl[6] = '{1'b1, 1'b0, 32'd1024, 32'h0,        5, 0, 4, 16'd0, 32'd5};
        tbl[7] = '{1'b0, 1'b1, 32'd1028, 32'h11,       5, 4, 0, 16'd1, 32'd5};
        tbl[8] = '{1'b1, 1'b0, 32'd0,    32'h0,        5, 0, 4, 16'hFF00, 32'h0};

        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; alu_res = 32'h0; st_val = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'h0, ready}, 32'h1);
        chk("rst_we", {31'h0, ext_we}, 32'h0);
        chk("rst_oe", {31'h0, ext_oe}, 32'h0);
        chk("rst_addr", {16'h0, ext_addr}, 32'h0);
        chk("rst_wdata", ext_wdata, 32'h0);
        chk("rst_memout", mem_out, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed table; rows 2/3 run back-to-back with no idle gap.
        for (int i = 0; i < 9; i++) begin
            do_op(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_timeout", i), {31'h0, op_to}, 32'h0);
            chk($sformatf("tbl%0d_stall", i), op_low, tbl[i].low);
            chk($sformatf("tbl%0d_we", i), op_we, tbl[i].we_n);
            chk($sformatf("tbl%0d_oe", i), op_oe, tbl[i].oe_n);
            chk($sformatf("tbl%0d_addr", i), {16'h0, op_addr}, {16'h0, tbl[i].addr});
            chk($sformatf("tbl%0d_out", i), op_out, tbl[i].out);
        end
        ref_mem[1] = 32'h11; ref_mem[2] = 32'h0; ref_mem[3] = 32'hA5A5A5A5; ref_mem[0] = 32'd5;
        last_out = 32'h0; last_word = 16'hFF00;

        // Reset during the second ACCESS cycle of a store.
        mem_w_en = 1'b1; alu_res = 32'd1028; st_val = 32'h12345678;
        @(posedge clk);           // -> ACCESS 1
        @(posedge clk); #1;       // in ACCESS 2
        chk("abort_we_before", {31'h0, ext_we}, 32'h1);
        rst = 1'b1; #1;
        chk("abort_we", {31'h0, ext_we}, 32'h0);
        chk("abort_ready", {31'h0, ready}, 32'h1);
        chk("abort_addr", {16'h0, ext_addr}, 32'h0);
        chk("abort_memout", mem_out, 32'h0);
        mem_w_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        last_out = 32'h0; last_word = -1;
        do_op(1'b1, 1'b0, 32'd1028, 32'h0);
        chk("abort_oldval", op_out, 32'h11);
        chk("abort_ld_stall", op_low, WS + 1);
        last_out = 32'h11; last_word = 1;

`ifdef MEM_RDBUF_EN
        run_op("rb_st", 1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        run_op("rb_ld1", 1'b1, 1'b0, 32'd1028, 32'h0);
        run_op("rb_ld2", 1'b1, 1'b0, 32'd1028, 32'h0);
        chk("rb_hit_stall", op_low, 0);
        chk("rb_hit_data", op_out, 32'hDEADBEEF);
        run_op("rb_st7", 1'b0, 1'b1, 32'd1028, 32'd7);
        run_op("rb_ld7", 1'b1, 1'b0, 32'd1028, 32'h0);
        chk("rb_wt_stall", op_low, 0);
        chk("rb_wt_data", op_out, 32'd7);
        run_op("rb_other", 1'b0, 1'b1, 32'd1040, 32'h99);
        run_op("rb_ld7b", 1'b1, 1'b0, 32'd1028, 32'h0);
`endif

        // Randomized ops: idle / load / store / both, mostly in a small window.
        for (int i = 0; i < 60; i++) begin
            int          kind;
            logic [31:0] a;
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) a = $urandom;
            else                           a = 32'd1024 + 4 * $urandom_range(0, 5);
            run_op($sformatf("rnd%0d", i), kind == 1 || kind == 3, kind >= 2, a, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
